// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Asynchronous serial receiver (8N1 by default) feeding a first-word-fall-through
// receive buffer. The line is oversampled using a shared 16x-baud clock-enable
// pulse; the processor pops bytes with a single-cycle read strobe.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   - one even-parity bit is expected between data and stop bits, and
//               the parity_error output is present.
//   undefined - plain 8N1 receiver, no parity_error port.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous active-high reset, clears all state
//   en_16_x_baud         single-cycle pulse at 16x the bit rate
//   serial_in            asynchronous serial line, idle high
//   read_buffer          pop strobe, one entry per cycle while non-empty
//   data_out             head entry of the buffer
//   buffer_data_present  buffer holds at least one entry
//   buffer_half_full     buffer holds at least FIFO_DEPTH/2 entries
//   buffer_full          buffer holds FIFO_DEPTH entries
//   framing_error        one-cycle pulse, stop bit sampled low
//   overflow             one-cycle pulse, good frame arrived while full
//   parity_error         (UART_RX_PARITY_EN only) one-cycle pulse on bad parity
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int START_VERIFY = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_16_x_baud,
   input  logic                 serial_in,
   input  logic                 read_buffer,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 buffer_data_present,
   output logic                 buffer_half_full,
   output logic                 buffer_full,
   output logic                 framing_error,
   output logic                 overflow
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_error
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [7:0]       VERIFY_LAST = 8'(START_VERIFY - 1);
   localparam logic [7:0]       TICK_LAST   = 8'd15;
   localparam logic [BIT_W-1:0] BITS_LAST   = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(FIFO_DEPTH / 2);

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // Stage p0/p1: two-flop synchronizer on the asynchronous line
   // ---------------------------------------------------------------------------
   logic rx_meta_p0;
   logic rx_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_meta_p0 <= serial_in;
         rx_s       <= rx_meta_p0;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame receiver state machine
   // ---------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [7:0]           tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 push_req;
   logic                 frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_err_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_ARM;
         tick_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         framing_error <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_error  <= par_err_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d   = 1'b0;
`endif
      if (en_16_x_baud) begin
         case (state_q)
            // Line must be seen high once so a low line at reset release is
            // not mistaken for a start bit.
            ST_ARM: begin
               if (rx_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            // Re-check the line near the start-bit centre; a high sample there
            // means the falling edge was a glitch.
            ST_START: begin
               if (tick_q == VERIFY_LAST) begin
                  tick_d = '0;
                  if (rx_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                  end
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
            // LSB arrives first, so shifting in at the MSB leaves the byte
            // correctly aligned after the last data bit.
            ST_DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits XOR parity bit must be zero.
            ST_PARITY: begin
               if (tick_q == TICK_LAST) begin
                  tick_d    = '0;
                  par_err_d = rx_s ^ (^shift_q);
                  state_d   = ST_STOP;
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
`endif
            // A low stop bit may be a break; return to ARM so the line must go
            // high again before another frame is accepted.
            ST_STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  if (rx_s) begin
                     push_req = 1'b1;
                     state_d  = ST_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_ARM;
                  end
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end
            default: state_d = ST_ARM;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Receive buffer: circular memory, pointers plus occupancy count
   // ---------------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_next;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 pop_ok, push_ok, drop, full_now;
   logic [DATA_BITS-1:0] head_d;

   // A pop on a full buffer frees the slot the concurrent push needs.
   assign full_now = (count_q == DEPTH_C);
   assign pop_ok   = read_buffer && (count_q != '0);
   assign push_ok  = push_req && (!full_now || pop_ok);
   assign drop     = push_req && full_now && !pop_ok;
   assign rd_next  = rd_ptr + PTR_W'(pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // The registered head must already show a byte being written into the
   // slot that becomes the head, hence the bypass from the incoming byte.
   always_comb begin
      head_d = data_out;
      if (count_d != '0) begin
         if (push_ok && (rd_next == wr_ptr)) begin
            head_d = shift_q;
         end else begin
            head_d = mem[rd_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= shift_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage p2: registered head and status flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         count_q             <= '0;
         data_out            <= '0;
         buffer_data_present <= 1'b0;
         buffer_half_full    <= 1'b0;
         buffer_full         <= 1'b0;
         overflow            <= 1'b0;
      end else begin
         wr_ptr              <= wr_ptr + PTR_W'(push_ok);
         rd_ptr              <= rd_next;
         count_q             <= count_d;
         data_out            <= head_d;
         buffer_data_present <= (count_d != '0);
         buffer_half_full    <= (count_d >= HALF_C);
         buffer_full         <= (count_d == DEPTH_C);
         overflow            <= drop;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Scoreboard bench for uart_rx_fifo. Frames are driven bit by bit on
// serial_in; the reference model is a bounded byte queue that follows the
// receiver's rules (good frame -> append if room, else overflow; bad stop ->
// framing error). A monitor compares every popped byte and counts pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int DATA_BITS    = 8;
   localparam int FIFO_DEPTH   = 16;
   localparam int START_VERIFY = 8;
   localparam int BIT_CLKS     = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS     = 1;
`else
   localparam int PAR_BITS     = 0;
`endif
   localparam int FRAME_BITS   = DATA_BITS + PAR_BITS + 2;
   // Clock edges from driving the start bit to the stop-bit decision:
   // 2 synchronizer flops + 1 edge to leave IDLE, start verify, then one
   // bit period per data/parity/stop bit.
   localparam int PUSH_CLK     = 3 + START_VERIFY + BIT_CLKS * (DATA_BITS + PAR_BITS + 1);

   logic       clk = 1'b0;
   logic       reset;
   logic       en_16_x_baud;
   logic       serial_in;
   logic       read_buffer;
   logic [7:0] data_out;
   logic       buffer_data_present;
   logic       buffer_half_full;
   logic       buffer_full;
   logic       framing_error;
   logic       overflow;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   uart_rx_fifo #(
      .DATA_BITS   (DATA_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .START_VERIFY(START_VERIFY)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .en_16_x_baud       (en_16_x_baud),
      .serial_in          (serial_in),
      .read_buffer        (read_buffer),
      .data_out           (data_out),
      .buffer_data_present(buffer_data_present),
      .buffer_half_full   (buffer_half_full),
      .buffer_full        (buffer_full),
      .framing_error      (framing_error),
      .overflow           (overflow)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_error       (parity_error)
`endif
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         exp_ovf = 0, exp_ferr = 0, exp_perr = 0;
   int         ovf_seen = 0, ferr_seen = 0, perr_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pulse counting and popped-byte comparison.
   always @(negedge clk) begin
      if (!reset) begin
         if (overflow) ovf_seen++;
         if (framing_error) ferr_seen++;
`ifdef UART_RX_PARITY_EN
         if (parity_error) perr_seen++;
`endif
         if (read_buffer) begin
            check("present_at_read", {31'd0, buffer_data_present}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) check("read_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] d, input bit stop, input bit flip, input int nbits);
      logic [15:0] lv;
      lv = 16'hFFFF;
      lv[0] = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) lv[1+i] = d[i];
      lv[15] = (^d) ^ flip;
`ifdef UART_RX_PARITY_EN
      lv[DATA_BITS+1] = lv[15];
`endif
      lv[FRAME_BITS-1] = stop;
      for (int i = 0; i < nbits; i++) begin
         serial_in = lv[i];
         wait_clks(BIT_CLKS);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip);
      drive_frame(d, stop, flip, FRAME_BITS);
      if (stop) begin
         if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
         else exp_ovf++;
      end else begin
         exp_ferr++;
         serial_in = 1'b1;
         wait_clks(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      if (flip) exp_perr++;
`endif
   endtask

   task automatic do_read();
      read_buffer = 1'b1;
      wait_clks(1);
      read_buffer = 1'b0;
   endtask

   task automatic check_flags(input string tag);
      int n;
      n = exp_q.size();
      check({tag, "_present"}, {31'd0, buffer_data_present}, {31'd0, n > 0});
      check({tag, "_half"},    {31'd0, buffer_half_full},    {31'd0, n >= FIFO_DEPTH / 2});
      check({tag, "_full"},    {31'd0, buffer_full},         {31'd0, n == FIFO_DEPTH});
      if (n > 0) check({tag, "_head"}, {24'd0, data_out}, {24'd0, exp_q[0]});
   endtask

   task automatic check_pulses(input string tag);
      check({tag, "_overflow_cnt"}, ovf_seen,  exp_ovf);
      check({tag, "_framing_cnt"},  ferr_seen, exp_ferr);
      check({tag, "_parity_cnt"},   perr_seen, exp_perr);
   endtask

   initial begin
      reset        = 1'b1;
      en_16_x_baud = 1'b1;
      serial_in    = 1'b1;
      read_buffer  = 1'b0;
      wait_clks(3);

      // Reset state
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_present",  {31'd0, buffer_data_present}, 32'd0);
      check("rst_half",     {31'd0, buffer_half_full}, 32'd0);
      check("rst_full",     {31'd0, buffer_full}, 32'd0);
      check("rst_framing",  {31'd0, framing_error}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      reset = 1'b0;
      wait_clks(20);

      // Single frame and pop
      send_frame(8'hA5, 1'b1, 1'b0);
      check("a5_data", {24'd0, data_out}, 32'hA5);
      check_flags("a5");
      do_read();
      check_flags("a5_popped");

      // Read while empty is ignored
      do_read();
      check_flags("empty_read");

      // Seventeen frames, no reads: half, full, overflow
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
         check_flags($sformatf("fill%0d", i));
      end
      check_pulses("fill");

      // Pop exactly on the push edge of a frame arriving while full
      fork
         send_frame(8'h55, 1'b1, 1'b0);
         begin
            repeat (PUSH_CLK - 1) @(posedge clk);
            #1 read_buffer = 1'b1;
            @(posedge clk);
            #1 read_buffer = 1'b0;
         end
      join
      check_pulses("simul");
      check_flags("simul");
      while (exp_q.size() > 0) do_read();
      check_flags("drained");

      // Bad stop bit, then a good frame of the same byte
      send_frame(8'h3C, 1'b0, 1'b0);
      check_pulses("framing");
      check_flags("framing");
      send_frame(8'h3C, 1'b1, 1'b0);
      check_flags("after_framing");
      do_read();

      // Short start glitch is rejected silently
      serial_in = 1'b0;
      wait_clks(4);
      serial_in = 1'b1;
      wait_clks(40);
      check_pulses("glitch");
      check_flags("glitch");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      check_pulses("par_good");
      send_frame(8'h07, 1'b1, 1'b1);
      check_pulses("par_bad");
      check_flags("par");
      while (exp_q.size() > 0) do_read();
`endif

      // Reset in the middle of bit 3 with entries queued
      for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check_flags("pre_reset");
      drive_frame(8'hC6, 1'b1, 1'b0, 4);
      serial_in = 1'b0;
      wait_clks(8);
      reset = 1'b1;
      exp_q.delete();
      wait_clks(2);
      check_flags("in_reset");
      check("in_reset_data", {24'd0, data_out}, 32'd0);
      serial_in = 1'b1;
      reset = 1'b0;
      wait_clks(20);
      check_flags("post_reset");
      send_frame(8'h9E, 1'b1, 1'b0);
      check_flags("post_reset_frame");
      do_read();

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         logic [7:0] d;
         bit         good;
         int         nrd;
         d    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 9) != 0);
         send_frame(d, good, 1'b0);
         check_flags($sformatf("rnd%0d", it));
         wait_clks($urandom_range(0, 20));
         nrd = $urandom_range(0, 2);
         for (int r = 0; r < nrd; r++) do_read();
      end
      check_pulses("rnd");
      while (exp_q.size() > 0) do_read();
      check_flags("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- 8N1 asynchronous serial receiver with a first-word-fall-through receive buffer.
- Companion to the team's UART transmit macro; sits between a device pin and a KCPSM3 input port.
- Samples at 16x baud, using a clock-enable pulse shared with the transmitter.
- Processor pops bytes with a one-cycle read strobe, decoded from the port address.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- FIFO_DEPTH, 16, buffer entries; power of two, 2..64.
- START_VERIFY, 8, en_16_x_baud ticks from start-edge detect to the start-bit mid-point check.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- en_16_x_baud  in  1  single-clk pulse at 16x bit rate; sampling advances only on these cycles.
- serial_in  in  1  asynchronous line, idle high.
- read_buffer  in  1  pop strobe; one entry removed per clk it is high and buffer non-empty.
- data_out  out  DATA_BITS  head entry; valid when buffer_data_present=1.
- buffer_data_present  out  1  count>0.
- buffer_half_full  out  1  count>=FIFO_DEPTH/2.
- buffer_full  out  1  count==FIFO_DEPTH.
- framing_error  out  1  one-clk pulse: stop bit sampled low.
- overflow  out  1  one-clk pulse: good frame arrived while full.

Behaviour:
- Reset values:
  - All outputs 0; data_out 0.
  - FIFO count 0.
  - Receiver in ARM.
  - Synchronizer flops 1.
- serial_in passes two flops (rx_s) before use. Pin-to-decision latency: 2 clk plus tick alignment.
- State machine; all transitions happen only on en_16_x_baud=1 unless stated otherwise.
  - ARM: waits for rx_s=1 on one tick, then goes to IDLE. Prevents a false start when the line is low as reset releases.
  - IDLE: rx_s=0 -> START, tick counter=0.
  - START: count START_VERIFY ticks.
    - rx_s=0 at count end -> DATA, bit index=0, counter=0.
    - rx_s=1 at count end -> IDLE (glitch rejected, no error flagged).
  - DATA: every 16th tick, shift rx_s into the MSB of the shift register (LSB-first assembly). After DATA_BITS samples -> STOP.
  - STOP: on the 16th tick sample rx_s.
    - 1: push the byte, then -> IDLE.
    - 0: discard the byte, pulse framing_error the next clk, then -> ARM. A break condition must end before the next frame.
- FIFO:
  - Circular, FIFO_DEPTH entries; write pointer and read pointer plus a count register.
  - A push occurs in the same clk as the STOP decision.
  - data_out is the head entry, registered from memory, and valid the same clk buffer_data_present rises.
  - Push when full: byte dropped, overflow pulses one clk, contents unchanged.
  - read_buffer while empty: ignored, pointers unchanged.
  - Simultaneous push and pop:
    - Non-empty: both occur, count unchanged.
    - Empty: the push occurs and the pop is ignored.
    - Full: the pop frees a slot, the push is accepted, and overflow does not pulse.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flags are derived from count, registered, and update the clk after the push/pop edge.
- Reset mid-frame: the partial byte is lost, the FIFO is emptied, and the receiver returns to ARM.
- en_16_x_baud held high continuously is legal: one tick per clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected after the data bits; state PARITY sits between DATA and STOP.
  - Extra output parity_error (1 bit, reset 0) pulses one clk when the parity sample mismatches the XOR of the data bits.
  - A byte with bad parity is still pushed if the stop bit is good.
- Undefined:
  - No PARITY state, no parity_error port; 8N1 only.

Test Plan:
- Reset, en_16_x_baud tied high, serial_in sends 0xA5 (8N1, 16 clk/bit) -> data_out=0xA5 and buffer_data_present=1 within 2 clk of the stop-bit mid-point. One read_buffer -> buffer_data_present=0.
- 17 consecutive frames 0x00..0x10, no reads -> buffer_half_full at the 8th, buffer_full at the 16th, overflow pulse on 0x10. Reads return 0x00..0x0F in order.
- Full buffer, read_buffer asserted on the exact push clk of frame 0x55 -> no overflow, count stays 16, last read returns 0x55.
- Frame 0x3C with stop bit forced low -> framing_error pulse, nothing pushed. Line held high for 1 bit, then frame 0x3C valid -> pushed.
- Start-bit glitch of 4 clk low -> no push, no error. Reset asserted during bit 3 of a frame with 5 entries queued -> all flags 0, next full frame received correctly.
- UART_RX_PARITY_EN: frame 0x07 with parity bit 1 -> byte pushed and parity_error 0. Same frame with parity bit 0 -> byte pushed and parity_error pulses.
